jk_bank_arbiter: RTL
====================

// Module: jk_bank_arbiter
// PURPOSE
//  - Bank of WIDTH JK flip-flop bits shared between NREQ requesters; round-robin arbiter, one JK command applied per cycle.
//  - Each requester gives a bit index and a {J,K} command and holds it until a registered one-cycle ack.
//  - Sits between software/FSM agents and the shared status/control bit bank; replaces per-agent direct JK flops.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  number of JK bits in the bank (2..64)
//  IDX_W  $clog2(WIDTH)  index width; localparam, not overridable
// PORTS
//  clk      in   1            rising-edge clock
//  rst_n    in   1            asynchronous reset, active-low
//  clr      in   1            synchronous clear of the bank; highest priority
//  req      in   NREQ         request per requester; level, held until ack
//  cmd_idx  in   NREQ*IDX_W   bit index, requester r at [r*IDX_W +: IDX_W]
//  cmd_jk   in   NREQ*2       {J,K}, requester r at [r*2 +: 2]
//  ack      out  NREQ         one-cycle pulse, command of requester r applied
//  q        out  WIDTH        bank state
//  err_oor  out  1            sticky: a granted cmd_idx was >= WIDTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): q=0, ack=0, err_oor=0, rr pointer=0. Mid-operation reset drops pending requests silently; no ack is issued.
//  - Eligibility at cycle t: req[r]=1 and ack[r]=0, so a requester that sees ack must not be re-granted the same cycle.
//  - Arbitration (combinational): first eligible r searching ptr, ptr+1, ..., wrapping mod NREQ.
//  - On rising edge after grant of r: q[idx_r] updated per {J,K}:
//      00 hold, 01 ->0, 10 ->1, 11 toggle. ack[r]=1 for exactly one cycle. ptr <= (r+1) mod NREQ.
//  - Latency: req asserted at cycle t with no contention -> q and ack change at edge t+1. Max throughput is 1 cmd/cycle overall and 1 cmd per 2 cycles per requester.
//  - No eligible requester: q holds, ack=0, ptr unchanged.
//  - idx >= WIDTH: grant and ack still occur, q unchanged, err_oor <= 1. err_oor clears only on reset.
//  - clr=1: q <= 0, no grant, ack=0, ptr unchanged. Requests remain pending and are served after clr deasserts.
//  - Requester dropping req before ack: command withdrawn, no ack, no effect.
//  - Only one bit changes per cycle. Simultaneous requests to the same bit are serialized in rr order, each seeing the prior result.
// CONFIGURATION
//  JK_ARB_STATS_EN defined:
//    - adds output toggle_cnt[15:0], reset 0.
//    - increments on each applied in-range 11 command; saturates at 16'hFFFF.
//    - clr does not clear it; only rst_n does.
//  JK_ARB_STATS_EN undefined: toggle_cnt port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset: rst_n=0 mid-stream with req=4'b1111 -> q=0, ack=0, err_oor=0 immediately (async). First grant after release goes to r0.
//  2. Single cmds, r1 only: idx=3: 10 -> q=8'h08; 11 -> q=8'h00; 11 -> q=8'h08; 01 -> q=8'h00; 00 -> unchanged. Each acked one cycle after req.
//  3. Round-robin: req=4'b1111 held, distinct idx, cmd 10 -> acks in order r0,r1,r2,r3,r0... one per cycle, no requester acked on two consecutive cycles.
//  4. Same bit contention: r0 and r2 both idx=5 cmd 11 from q=0 -> after both acks q[5]=0, toggled twice.
//  5. Out of range, WIDTH=6: idx=7 cmd 10 -> ack pulses, q unchanged, err_oor=1 and stays 1 until reset.
//  6. clr: q=8'hFF, clr=1 for 2 cycles while r0 requests idx 0 cmd 10 -> q=0, no ack during clr; ack next cycle after clr low, q=8'h01. With JK_ARB_STATS_EN: 3 toggle cmds -> toggle_cnt=3.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: bank of WIDTH JK bits shared by NREQ requesters.
// A round-robin arbiter applies one {J,K} command per cycle and returns
// a registered one-cycle ack to the requester that was served.
// Optional feature macro: JK_ARB_STATS_EN adds a saturating toggle_cnt
// output that counts applied in-range toggle (11) commands.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*$clog2(WIDTH)-1:0]   cmd_idx,
  input  logic [NREQ*2-1:0]               cmd_jk,
  output logic [NREQ-1:0]                 ack,
  output logic [WIDTH-1:0]                q,
  output logic                            err_oor
`ifdef JK_ARB_STATS_EN
  ,
  output logic [15:0]                     toggle_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [NREQ-1:0]  eligible;
  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_id;
  logic [IDX_W-1:0] gnt_idx;
  logic [1:0]       gnt_jk;
  logic             in_range;
  logic             do_grant;
  logic [NREQ-1:0]  ack_next;
  logic [WIDTH-1:0] q_next;
  int unsigned      cand;

  // Round-robin search starting at ptr; a requester being acked is skipped
  always_comb begin
    eligible  = req & ~ack;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_valid && eligible[PTR_W'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_id    = PTR_W'(cand);
      end
    end
  end

  // Select the winner's command and derive grant side effects
  always_comb begin
    gnt_idx = '0;
    gnt_jk  = 2'b00;
    for (int r = 0; r < int'(NREQ); r++) begin
      if (gnt_id == PTR_W'(r)) begin
        gnt_idx = cmd_idx[r*IDX_W +: IDX_W];
        gnt_jk  = cmd_jk[r*2 +: 2];
      end
    end
    in_range = ({1'b0, gnt_idx} < (IDX_W+1)'(WIDTH));
    do_grant = gnt_valid && !clr;
    ptr_next = (gnt_id == PTR_W'(NREQ - 1)) ? '0 : gnt_id + PTR_W'(1);
    ack_next = do_grant ? (NREQ'(1) << gnt_id) : '0;
  end

  // Next bank state: clear wins, otherwise the granted in-range bit follows JK
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (do_grant && in_range) begin
      for (int b = 0; b < int'(WIDTH); b++) begin
        if (gnt_idx == IDX_W'(b)) begin
          case (gnt_jk)
            2'b01:   q_next[b] = 1'b0;
            2'b10:   q_next[b] = 1'b1;
            2'b11:   q_next[b] = ~q[b];
            default: q_next[b] = q[b];
          endcase
        end
      end
    end
  end

  // Bank, ack, pointer and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      ack     <= '0;
      ptr     <= '0;
      err_oor <= 1'b0;
    end else begin
      q   <= q_next;
      ack <= ack_next;
      if (do_grant) begin
        ptr <= ptr_next;
        if (!in_range) err_oor <= 1'b1;
      end
    end
  end

`ifdef JK_ARB_STATS_EN
  // Saturating count of applied in-range toggle commands; unaffected by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if (do_grant && in_range && (gnt_jk == 2'b11) && (toggle_cnt != 16'hFFFF)) begin
      toggle_cnt <= toggle_cnt + 16'd1;
    end
  end
`endif

endmodule
